// File: rtl/alu_pkg.sv
// Shared MiniMicro ALU definitions: operand widths, opcode set, flag bit positions
// and the registered result/flags payload.
package alu_pkg;

  localparam int unsigned WIDTH  = 32;
  localparam int unsigned OP_W   = 5;
  localparam int unsigned SH_W   = 5;
  localparam int unsigned FLAG_W = 4;

  // Full MiniMicro opcode map; this slice implements ANDS, ADCS, ADDS and ASR.
  localparam logic [OP_W-1:0] MOVS = 5'd0;
  localparam logic [OP_W-1:0] ANDS = 5'd1;
  localparam logic [OP_W-1:0] EORS = 5'd2;
  localparam logic [OP_W-1:0] LSLS = 5'd3;
  localparam logic [OP_W-1:0] LSRS = 5'd4;
  localparam logic [OP_W-1:0] ADCS = 5'd5;
  localparam logic [OP_W-1:0] ADDS = 5'd6;
  localparam logic [OP_W-1:0] SBCS = 5'd7;
  localparam logic [OP_W-1:0] SUBS = 5'd8;
  localparam logic [OP_W-1:0] RSBS = 5'd9;
  localparam logic [OP_W-1:0] CMP  = 5'd10;
  localparam logic [OP_W-1:0] CMN  = 5'd11;
  localparam logic [OP_W-1:0] ASR  = 5'd12;
  localparam logic [OP_W-1:0] ORRS = 5'd13;
  localparam logic [OP_W-1:0] MULS = 5'd14;
  localparam logic [OP_W-1:0] BICS = 5'd15;
  localparam logic [OP_W-1:0] MVNS = 5'd16;

  // Flag nibble bit positions
  localparam int unsigned NEGATIVE = 0;
  localparam int unsigned ZERO     = 1;
  localparam int unsigned CARRY    = 2;
  localparam int unsigned OVERFLOW = 3;

  typedef struct packed {
    logic [WIDTH-1:0]  result;
    logic [FLAG_W-1:0] flags;
  } alu_out_t;

  function automatic logic is_zero(input logic [WIDTH-1:0] value);
    return value == '0;
  endfunction

endpackage

// File: rtl/carry_adder32.sv
// 32-bit combinational adder with carry in and carry out.
module carry_adder32
  import alu_pkg::*;
(
  input  logic [WIDTH-1:0] num1,
  input  logic [WIDTH-1:0] num2,
  input  logic             c_in,
  output logic [WIDTH-1:0] sum,
  output logic             c_out
);

  logic [WIDTH:0] total;

  assign total = {1'b0, num1} + {1'b0, num2} + (WIDTH+1)'(c_in);
  assign sum   = total[WIDTH-1:0];
  assign c_out = total[WIDTH];

endmodule

// File: rtl/ands_asr_adder.sv
// Registered ANDS / ASR / ADDS / ADCS execution slice with NZCV flags.
// Define ANDS_ASR_ADDER_OVF_EN to compute V for adds; otherwise V is held at 0.
module ands_asr_adder
  import alu_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [OP_W-1:0]   instruction,
  input  logic [WIDTH-1:0]  num1,
  input  logic [WIDTH-1:0]  num2,
  output logic [WIDTH-1:0]  result,
  output logic [FLAG_W-1:0] flags,
  output logic              valid
);

  alu_out_t         q;
  alu_out_t         nxt;
  logic             nxt_valid;

  logic [WIDTH-1:0] and_res;
  logic [WIDTH-1:0] asr_res;
  logic [SH_W-1:0]  sh;
  logic             asr_c;
  logic             add_cin;
  logic [WIDTH-1:0] add_sum;
  logic             add_cout;
  logic             add_ovf;
  logic             v_keep;

  assign sh      = num2[SH_W-1:0];
  assign and_res = num1 & num2;
  assign asr_res = WIDTH'($signed(num1) >>> sh);
  // Last bit shifted out; a zero shift leaves carry untouched
  assign asr_c   = (sh == '0) ? q.flags[CARRY] : num1[SH_W'(sh - SH_W'(1))];
  assign add_cin = (instruction == ADCS) ? q.flags[CARRY] : 1'b0;

  carry_adder32 u_adder (
    .num1  (num1),
    .num2  (num2),
    .c_in  (add_cin),
    .sum   (add_sum),
    .c_out (add_cout)
  );

`ifdef ANDS_ASR_ADDER_OVF_EN
  assign add_ovf = (num1[WIDTH-1] == num2[WIDTH-1]) && (add_sum[WIDTH-1] != num1[WIDTH-1]);
  assign v_keep  = q.flags[OVERFLOW];
`else
  assign add_ovf = 1'b0;
  assign v_keep  = 1'b0;
`endif

  // Operation select and next-state flags
  always_comb begin
    nxt       = q;
    nxt_valid = 1'b0;
    if (en) begin
      case (instruction)
        ANDS: begin
          nxt.result          = and_res;
          nxt.flags[NEGATIVE] = and_res[WIDTH-1];
          nxt.flags[ZERO]     = is_zero(and_res);
          nxt.flags[CARRY]    = 1'b0;
          nxt.flags[OVERFLOW] = v_keep;
          nxt_valid           = 1'b1;
        end
        ADDS, ADCS: begin
          nxt.result          = add_sum;
          nxt.flags[NEGATIVE] = add_sum[WIDTH-1];
          nxt.flags[ZERO]     = is_zero(add_sum);
          nxt.flags[CARRY]    = add_cout;
          nxt.flags[OVERFLOW] = add_ovf;
          nxt_valid           = 1'b1;
        end
        ASR: begin
          nxt.result          = asr_res;
          nxt.flags[NEGATIVE] = asr_res[WIDTH-1];
          nxt.flags[ZERO]     = is_zero(asr_res);
          nxt.flags[CARRY]    = asr_c;
          nxt.flags[OVERFLOW] = v_keep;
          nxt_valid           = 1'b1;
        end
        default: begin
          nxt.result = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q     <= '0;
      valid <= 1'b0;
    end else begin
      q     <= nxt;
      valid <= nxt_valid;
    end
  end

  assign result = q.result;
  assign flags  = q.flags;

endmodule

// File: tb/tb_ands_asr_adder.sv
// Self-checking bench for ands_asr_adder: directed vector table, a carry-chain
// sequence, and randomized traffic against an arithmetic reference model.
module tb_ands_asr_adder;

`ifdef ANDS_ASR_ADDER_OVF_EN
  localparam bit OVF = 1'b1;
`else
  localparam bit OVF = 1'b0;
`endif

  localparam logic [4:0] OP_ANDS = 5'd1;
  localparam logic [4:0] OP_ADCS = 5'd5;
  localparam logic [4:0] OP_ADDS = 5'd6;
  localparam logic [4:0] OP_ASR  = 5'd12;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic [4:0]  instruction;
  logic [31:0] num1;
  logic [31:0] num2;
  logic [31:0] result;
  logic [3:0]  flags;
  logic        valid;

  int n_cmp  = 0;
  int n_fail = 0;

  ands_asr_adder dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (en),
    .instruction (instruction),
    .num1        (num1),
    .num2        (num2),
    .result      (result),
    .flags       (flags),
    .valid       (valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst_n;
    logic        en;
    logic [4:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] r;
    logic [3:0]  f;   // {V,C,Z,N}
    logic        v;
  } vec_t;

  vec_t vecs[17];

  // Reference model state
  logic [31:0] m_result;
  logic [3:0]  m_flags;
  logic        m_valid;

  function automatic vec_t mk(input logic rn, input logic e, input logic [4:0] op,
                              input logic [31:0] a, input logic [31:0] b,
                              input logic [31:0] r, input logic [3:0] f, input logic v);
    vec_t t;
    t.rst_n = rn; t.en = e; t.op = op; t.a = a; t.b = b; t.r = r; t.f = f; t.v = v;
    return t;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic apply(input logic rn, input logic e, input logic [4:0] op,
                       input logic [31:0] a, input logic [31:0] b);
    rst_n = rn; en = e; instruction = op; num1 = a; num2 = b;
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string tag, input logic [31:0] r, input logic [3:0] f, input logic v);
    check({tag, ".result"}, result, r);
    check({tag, ".flags"}, 32'(flags), 32'(f));
    check({tag, ".valid"}, 32'(valid), 32'(v));
  endtask

  // Behavioural model: plain wide arithmetic on the architectural rules
  task automatic model_step(input logic rn, input logic e, input logic [4:0] op,
                            input logic [31:0] a, input logic [31:0] b);
    longint unsigned usum;
    longint          ssum;
    int              sh;
    logic [31:0]     r;
    if (!rn) begin
      m_result = 0; m_flags = 0; m_valid = 0;
      return;
    end
    m_valid = 0;
    if (!e) return;
    if (op == OP_ANDS) begin
      r = a & b;
      m_flags[2] = 0;
      m_valid = 1;
    end else if (op == OP_ADDS || op == OP_ADCS) begin
      usum = longint'(a) + longint'(b) + ((op == OP_ADCS) ? longint'(m_flags[2]) : 0);
      ssum = longint'($signed(a)) + longint'($signed(b)) + ((op == OP_ADCS) ? longint'(m_flags[2]) : 0);
      r = usum[31:0];
      m_flags[2] = usum[32];
      m_flags[3] = OVF && (ssum > 64'sd2147483647 || ssum < -64'sd2147483648);
      m_valid = 1;
    end else if (op == OP_ASR) begin
      sh = int'(b[4:0]);
      if (sh == 0) r = a;
      else begin
        r = 32'(longint'($signed(a)) >>> sh);
        m_flags[2] = a[sh-1];
      end
      m_valid = 1;
    end else begin
      m_result = 0;
      return;
    end
    if (!OVF) m_flags[3] = 0;
    m_result = r;
    m_flags[0] = r[31];
    m_flags[1] = (r == 0);
  endtask

  initial begin
    logic [4:0]  op;
    logic [31:0] a, b;
    logic        rn, e;

    rst_n = 1'b0; en = 1'b0; instruction = '0; num1 = '0; num2 = '0;

    vecs[0]  = mk(0, 1, OP_ADDS, 32'd5, 32'd6, 32'd0, 4'b0000, 0);
    vecs[1]  = mk(0, 1, OP_ADDS, 32'd5, 32'd6, 32'd0, 4'b0000, 0);
    vecs[2]  = mk(1, 1, OP_ADDS, 32'd5, 32'd6, 32'd11, 4'b0000, 1);
    vecs[3]  = mk(1, 1, OP_ADDS, 32'hFFFF_FFFF, 32'd1, 32'd0, 4'b0110, 1);
    vecs[4]  = mk(1, 1, OP_ANDS, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'h00F0_00F0, 4'b0000, 1);
    vecs[5]  = mk(1, 1, OP_ADDS, 32'hFFFF_FFFF, 32'd1, 32'd0, 4'b0110, 1);
    vecs[6]  = mk(1, 1, OP_ADCS, 32'd0, 32'd0, 32'd1, 4'b0000, 1);
    vecs[7]  = mk(1, 1, OP_ADDS, 32'h7FFF_FFFF, 32'd1, 32'h8000_0000, {OVF, 3'b001}, 1);
    vecs[8]  = mk(1, 1, OP_ASR, 32'h8000_0000, 32'd4, 32'hF800_0000, {OVF, 3'b001}, 1);
    vecs[9]  = mk(1, 1, OP_ASR, 32'h0000_0003, 32'd1, 32'd1, {OVF, 3'b100}, 1);
    vecs[10] = mk(1, 1, OP_ASR, 32'h1234_5678, 32'hFFFF_FFE0, 32'h1234_5678, {OVF, 3'b100}, 1);
    vecs[11] = mk(1, 1, 5'd2, 32'd7, 32'd9, 32'd0, {OVF, 3'b100}, 0);
    vecs[12] = mk(1, 1, OP_ADDS, 32'd1, 32'd1, 32'd2, 4'b0000, 1);
    vecs[13] = mk(1, 0, OP_ADDS, 32'd5, 32'd5, 32'd2, 4'b0000, 0);
    vecs[14] = mk(1, 1, OP_ASR, 32'h4000_0000, 32'd31, 32'd0, 4'b0110, 1);
    vecs[15] = mk(0, 1, OP_ADDS, 32'd3, 32'd4, 32'd0, 4'b0000, 0);
    vecs[16] = mk(1, 1, OP_ADCS, 32'hFFFF_FFFF, 32'd0, 32'hFFFF_FFFF, 4'b0001, 1);

    for (int i = 0; i < 17; i++) begin
      apply(vecs[i].rst_n, vecs[i].en, vecs[i].op, vecs[i].a, vecs[i].b);
      check_all($sformatf("vec%0d", i), vecs[i].r, vecs[i].f, vecs[i].v);
    end

    // Carry chain: 64-bit add 0x00000001_80000000 + 0x00000002_80000000
    apply(1, 1, OP_ADDS, 32'h8000_0000, 32'h8000_0000);
    check_all("chain_lo", 32'd0, {OVF, 3'b110}, 1);
    apply(1, 1, OP_ADCS, 32'd1, 32'd2);
    check_all("chain_hi", 32'd4, 4'b0000, 1);

    // ADCS back-to-back without carry, then a held cycle keeps carry for a later ADCS
    apply(1, 1, OP_ADDS, 32'hFFFF_FFFE, 32'd3);
    check_all("hold_pre", 32'd1, 4'b0100, 1);
    apply(1, 0, OP_ADDS, 32'd0, 32'd0);
    check_all("hold_mid", 32'd1, 4'b0100, 0);
    apply(1, 1, OP_ADCS, 32'd10, 32'd20);
    check_all("hold_post", 32'd31, 4'b0000, 1);

    // Randomized traffic against the reference model, starting from reset
    model_step(0, 1, OP_ADDS, 0, 0);
    apply(0, 1, OP_ADDS, 0, 0);
    check_all("rnd_rst", m_result, m_flags, m_valid);
    for (int i = 0; i < 600; i++) begin
      rn = ($urandom_range(0, 39) != 0);
      e  = ($urandom_range(0, 3) != 0);
      case ($urandom_range(0, 4))
        0: op = OP_ANDS;
        1: op = OP_ADCS;
        2: op = OP_ADDS;
        3: op = OP_ASR;
        default: op = 5'($urandom_range(0, 31));
      endcase
      a = $urandom();
      b = $urandom();
      case ($urandom_range(0, 7))
        0: a = 32'h7FFF_FFFF;
        1: a = 32'h8000_0000;
        2: b = 32'hFFFF_FFFF;
        3: b = {27'($urandom()), 5'd0};
        default: ;
      endcase
      model_step(rn, e, op, a, b);
      apply(rn, e, op, a, b);
      check_all($sformatf("rnd%0d", i), m_result, m_flags, m_valid);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/ands_asr_adder.md
# ands_asr_adder

Registered 32-bit execution slice of the MiniMicro ALU covering bitwise AND (ANDS), arithmetic shift right (ASR) and addition with/without carry-in (ADDS/ADCS). It takes a 5-bit instruction code from the decode stage and two 32-bit operands. It produces a registered result plus a registered NZCV flag nibble, and that flag nibble also supplies the carry-in for ADCS.

## Interface
- WIDTH, 32, operand/result width (only 32 supported; shift amount uses `num2[4:0]`)
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset
- en  in  1  execute strobe; instruction sampled only when high
- instruction  in  5  opcode: ANDS=1, ADCS=5, ADDS=6, ASR=12
- num1  in  32  operand A (value to shift for ASR)
- num2  in  32  operand B (shift amount in bits [4:0] for ASR)
- result  out  32  registered result
- flags  out  4  registered flags, bit 0=N, 1=Z, 2=C, 3=V
- valid  out  1  high for one cycle after an accepted supported instruction

## Operation
- ANDS: result = num1 & num2; N = result[31]; Z = (result==0); C cleared to 0; V unchanged.
- ADDS: {c,sum} = num1 + num2 (33-bit); result = sum; N, Z from sum; C = bit 32; V = signed overflow (see Configuration).
- ADCS: as ADDS but + flags[C] (current registered carry) as carry-in.
- ASR, sh = num2[4:0]:
  - sh=0: result = num1; C unchanged.
  - sh>0: result = $signed(num1) >>> sh; C = num1[sh-1] (last bit shifted out).
  - N, Z from result; V unchanged.
- Unsupported opcode with en=1: result <= 0, flags hold, valid=0.
- en=0: result, flags hold; valid=0.
- Overflow rule for add: V = (num1[31]==num2[31]) && (sum[31]!=num1[31]).

## Timing
- Latency 1 cycle: operands/opcode sampled at rising edge with en=1; result, flags, valid updated at that same edge and visible for the following cycle.
- Back-to-back instructions every cycle supported. ADCS uses flags as they stand before the edge, so ADDS followed by ADCS chains carry correctly.
- Reset: rst_n low at a rising edge gives result=0, flags=4'b0000, valid=0. Reset has priority over en, including mid-stream.
- No handshake/backpressure; valid is informational only.

## Configuration
- ANDS_ASR_ADDER_OVF_EN defined: V is computed for ADDS/ADCS per the overflow rule above.
- Undefined: overflow logic is omitted; V is forced to 0 on every update and out of reset; all other behaviour is identical.

## Structure
- Shared package `alu_pkg`: opcode localparams (ANDS, ADCS, ADDS, ASR and the full codebase set), flag index constants NEGATIVE=0, ZERO=1, CARRY=2, OVERFLOW=3.
- One sub-module: `carry_adder32` (num1, num2, c_in → sum, c_out), combinational. AND and ASR are inline combinational logic.
- Top: operation mux feeding a single registered result/flags/valid stage.

## Test plan
- Reset: hold rst_n=0 with en=1, ADDS 5+6 → result=0, flags=0000, valid=0. Release → next ADDS gives result=11, valid=1 one cycle later.
- ANDS 0xF0F0F0F0 & 0x0FF00FF0 → 0x00F000F0, N=0 Z=0 C=0; with prior C=1, C is cleared.
- ADDS 0xFFFFFFFF + 1 → result 0, Z=1 C=1 N=0 V=0. Then ADCS 0 + 0 → result 1, C=0 Z=0.
- ADDS 0x7FFFFFFF + 1 → 0x80000000, N=1, V=1 with ANDS_ASR_ADDER_OVF_EN defined, V=0 without.
- ASR 0x80000000 by 4 → 0xF8000000, N=1 C=0. ASR 0x00000003 by 1 → 1, C=1. ASR by 0 with C=1 → result=num1, C stays 1.
- Opcode 2 with en=1 → result 0, flags unchanged, valid=0. en=0 with ADDS → result, flags hold.
